// File: rtl/multi_tone_gen.sv
// multi_tone_gen: NCH-channel square-wave generator with shadowed half-period retuning.
// Optional feature macro: MULTI_TONE_PRESCALE_EN (global tick prescaler of PRESCALE clocks).
// Ports:
//   clk      - system clock, rising edge
//   nreset   - asynchronous active-low reset
//   wr_en    - single-cycle half-period write strobe
//   wr_ch    - channel addressed by the write (ignored when >= NCH)
//   wr_data  - new half-period value
//   en       - per-channel run enable
//   tone_out - per-channel square wave
//   wrap     - one-clk pulse when the channel's tone_out toggles
//   pending  - a shadow half-period is waiting for the next wrap
module multi_tone_gen #(
    parameter int NCH      = 4,
    parameter int CW       = 32,
    parameter int PRESCALE = 24,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [CW-1:0]  wr_data,
    input  logic [NCH-1:0] en,
    output logic [NCH-1:0] tone_out,
    output logic [NCH-1:0] wrap,
    output logic [NCH-1:0] pending
);
    logic w_tick;
`ifdef MULTI_TONE_PRESCALE_EN
    localparam int PW = $clog2(PRESCALE);
    logic [PW-1:0] r_pre;
    assign w_tick = (r_pre == PW'(PRESCALE - 1));
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_pre <= '0;
        else         r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end
`else
    // Every clk is a tick; PRESCALE is inert in this build.
    assign w_tick = 1'b1 | (PRESCALE < 2);
`endif
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] r_cnt, r_hp_act, r_hp_sh;
        logic          r_tone, r_wrap, r_pend;
        logic          w_wr, w_hit;
        // Out-of-range wr_ch matches no channel, so such writes vanish.
        assign w_wr  = wr_en && (wr_ch == CHW'(i));
        assign w_hit = w_tick && (r_cnt == r_hp_act);
        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                r_cnt    <= '0;
                r_hp_act <= '0;
                r_hp_sh  <= '0;
                r_tone   <= 1'b0;
                r_wrap   <= 1'b0;
                r_pend   <= 1'b0;
            end else if (!en[i]) begin
                r_cnt  <= '0;
                r_tone <= 1'b0;
                r_wrap <= 1'b0;
                r_pend <= 1'b0;
                if (w_wr)        r_hp_act <= wr_data;
                else if (r_pend) r_hp_act <= r_hp_sh;
            end else if (w_hit) begin
                // Wrap: the only point where a running channel may retune,
                // so hp_act never drops below cnt.
                r_cnt  <= '0;
                r_tone <= ~r_tone;
                r_wrap <= 1'b1;
                r_pend <= 1'b0;
                if (w_wr)        r_hp_act <= wr_data;
                else if (r_pend) r_hp_act <= r_hp_sh;
            end else begin
                r_wrap <= 1'b0;
                if (w_tick) r_cnt <= r_cnt + 1'b1;
                if (w_wr) begin
                    r_hp_sh <= wr_data;
                    r_pend  <= 1'b1;
                end
            end
        end
        assign tone_out[i] = r_tone;
        assign wrap[i]     = r_wrap;
        assign pending[i]  = r_pend;
    end
endmodule

// File: tb/tb_multi_tone_gen.sv
// tb_multi_tone_gen: randomized and directed checks of multi_tone_gen against a tick-level reference model.
module tb_multi_tone_gen;
    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int DUT_PRESCALE = 4;
`ifdef MULTI_TONE_PRESCALE_EN
    localparam int TP = DUT_PRESCALE;
`else
    localparam int TP = 1;
`endif

    logic           clk = 1'b0;
    logic           nreset = 1'b0;
    logic           wr_en = 1'b0;
    logic [1:0]     wr_ch = '0;
    logic [CW-1:0]  wr_data = '0;
    logic [NCH-1:0] en = '0;
    logic [NCH-1:0] tone_out, wrap, pending;

    multi_tone_gen #(.NCH(NCH), .CW(CW), .PRESCALE(DUT_PRESCALE)) dut (
        .clk(clk), .nreset(nreset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .en(en), .tone_out(tone_out), .wrap(wrap), .pending(pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: ticks elapsed in the current half period, active
    // half-period length, and a queue of shadow writes (last one wins).
    int       m_pre;
    int       m_el [NCH];
    int       m_hp [NCH];
    int       m_sh [NCH][$];
    bit [NCH-1:0] m_tone, m_wrap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0;
        m_tone = '0;
        m_wrap = '0;
        for (int c = 0; c < NCH; c++) begin
            m_el[c] = 0;
            m_hp[c] = 0;
            m_sh[c].delete();
        end
    endtask

    function automatic bit [NCH-1:0] m_pending();
        bit [NCH-1:0] p;
        for (int c = 0; c < NCH; c++) p[c] = (m_sh[c].size() != 0);
        return p;
    endfunction

    task automatic model_step();
        bit tick, wr;
        int nxt;
        if (!nreset) begin
            model_reset();
            return;
        end
        tick  = (m_pre == TP - 1);
        m_pre = (m_pre + 1) % TP;
        for (int c = 0; c < NCH; c++) begin
            wr = wr_en && (int'(wr_ch) == c);
            m_wrap[c] = 1'b0;
            if (!en[c]) begin
                m_el[c] = 0;
                m_tone[c] = 1'b0;
                if (wr) m_hp[c] = int'(wr_data);
                else if (m_sh[c].size() != 0) m_hp[c] = m_sh[c][$];
                m_sh[c].delete();
            end else if (tick && (m_el[c] + 1 == m_hp[c] + 1)) begin
                m_tone[c] = ~m_tone[c];
                m_wrap[c] = 1'b1;
                m_el[c] = 0;
                nxt = m_hp[c];
                if (m_sh[c].size() != 0) nxt = m_sh[c][$];
                if (wr) nxt = int'(wr_data);
                m_hp[c] = nxt;
                m_sh[c].delete();
            end else begin
                if (tick) m_el[c]++;
                if (wr) m_sh[c].push_back(int'(wr_data));
            end
        end
    endtask

    function automatic bit wraps_next(input int c);
        return nreset && en[c] && (m_pre == TP - 1) && (m_el[c] == m_hp[c]);
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check("tone", 32'(tone_out), 32'(m_tone));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("pending", 32'(pending), 32'(m_pending()));
    endtask

    task automatic wr(input int ch, input int d);
        wr_en = 1'b1;
        wr_ch = 2'(ch);
        wr_data = CW'(d);
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic run_random(input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(15) == 0) en[$urandom_range(NCH - 1)] ^= 1'b1;
            wr_en = ($urandom_range(3) == 0);
            wr_ch = 2'($urandom_range(3));
            wr_data = CW'($urandom_range(5));
            cycle();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        int last, ticks;
        bit found;
        model_reset();
        cycle();
        cycle();
        check("reset_tone", 32'(tone_out), 0);
        check("reset_pending", 32'(pending), 0);
        @(negedge clk);
        nreset = 1'b1;
        cyc++;

        // ch0 at hp=3 written while disabled: toggles every 4 ticks
        wr(0, 3);
        check("dis_wr_no_pending", 32'(pending[0]), 0);
        en[0] = 1'b1;
        last = -1;
        for (int k = 0; k < 32 * TP; k++) begin
            cycle();
            if (wrap[0]) begin
                if (last >= 0) check("ch0_interval", 32'(cyc - last), 32'(4 * TP));
                last = cyc;
            end
        end
        // retune mid-half-period
        cycle();
        wr(0, 7);
        check("ch0_pending_set", 32'(pending[0]), 1);
        for (int k = 0; k < 40 * TP; k++) cycle();

        // ch1: two writes before the wrap, last wins
        wr(1, 3);
        en[1] = 1'b1;
        cycle();
        wr(1, 5);
        wr(1, 9);
        for (int k = 0; k < 30 * TP; k++) cycle();
        // write exactly on a wrap clk goes straight to the active value
        found = 1'b0;
        for (int k = 0; k < 40 * TP && !found; k++) begin
            if (wraps_next(1)) found = 1'b1;
            else cycle();
        end
        check("ch1_wrap_found", 32'(found), 1);
        wr(1, 2);
        check("ch1_wrap_wr_wrap", 32'(wrap[1]), 1);
        check("ch1_wrap_wr_pending", 32'(pending[1]), 0);
        for (int k = 0; k < 12 * TP; k++) cycle();

        // ch2: drop enable with a pending value, then re-enable
        wr(2, 4);
        en[2] = 1'b1;
        for (int k = 0; k < 3 * TP; k++) cycle();
        wr(2, 6);
        check("ch2_pending_set", 32'(pending[2]), 1);
        en[2] = 1'b0;
        cycle();
        check("ch2_drop_tone", 32'(tone_out[2]), 0);
        check("ch2_drop_pending", 32'(pending[2]), 0);
        en[2] = 1'b1;
        ticks = 0;
        found = 1'b0;
        for (int k = 0; k < 7 * TP + 4 && !found; k++) begin
            if (m_pre == TP - 1) ticks++;
            cycle();
            if (wrap[2]) found = 1'b1;
        end
        check("ch2_reenable_found", 32'(found), 1);
        check("ch2_first_toggle_ticks", 32'(ticks), 7);

        // out-of-range channel: nothing changes
        for (int k = 0; k < 6; k++) wr(3, k);

        run_random(800);

        // asynchronous reset mid-operation
        en = '1;
        for (int k = 0; k < 5; k++) cycle();
        #2;
        nreset = 1'b0;
        #1;
        check("async_rst_tone", 32'(tone_out), 0);
        check("async_rst_wrap", 32'(wrap), 0);
        check("async_rst_pending", 32'(pending), 0);
        model_reset();
        cycle();
        @(negedge clk);
        nreset = 1'b1;
        en = '0;
        cyc++;
        run_random(800);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end
endmodule
